// File: rtl/riscv_pkg.sv
// Shared RV32I decode helpers: opcode constants, forwarding selects and the
// shadow-pipe entry used by the hazard controller.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } shadow_entry_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return opc inside {OP, OP_IMM, JALR, LOAD, STORE, BRANCH};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OP, STORE, BRANCH};
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        return opc inside {OP, OP_IMM, JALR, LOAD, LUI, JAL};
    endfunction

    function automatic logic is_load(input logic [6:0] opc);
        return opc == LOAD;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one source register, evaluated against the
// EX/MEM occupants as they will sit one cycle later.
module fwd_select
    import riscv_pkg::*;
(
    input  shadow_entry_t ex,
    input  shadow_entry_t mem,
    input  logic [4:0]    src,
    input  logic          used,
    output fwd_sel_e      sel
);

    always_comb begin
        sel = FWD_RF;
        if (used) begin
            // A load in EX has no result at MEM yet; its data arrives via WB.
            if (ex.valid && ex.wr && !ex.ld && ex.rd == src)
                sel = FWD_MEM;
            else if (mem.valid && mem.wr && mem.rd == src)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / redirect flush sequencing and registered forwarding selects
// for a 5-stage RV32I pipeline, driven from a shadow record of EX/MEM/WB.
module pipe_hazard_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_redirect,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    typedef enum logic {RUN, STALL} state_e;

    state_e state_q, state_nxt;

    // sh_q[0]=EX, sh_q[1]=MEM, sh_q[2]=WB
    shadow_entry_t [2:0] sh_q;
    shadow_entry_t       ex_q, mem_q, id_ent, ex_nxt;

    logic             advance, hazard;
    logic [1:0]       op_used;
    logic [1:0][4:0]  op_src;
    fwd_sel_e         op_sel [2];

    assign ex_q  = sh_q[0];
    assign mem_q = sh_q[1];

    always_comb begin
        id_ent.valid = id_valid;
        id_ent.rd    = id_rd;
        id_ent.wr    = writes_rd(id_opcode) && (id_rd != 5'd0);
        id_ent.ld    = is_load(id_opcode);
    end

    assign op_used = {uses_rs2(id_opcode), uses_rs1(id_opcode)};
    assign op_src  = {id_rs2, id_rs1};

    assign hazard = id_valid && ex_q.valid && ex_q.ld && ex_q.wr &&
                    ((op_used[0] && id_rs1 == ex_q.rd) ||
                     (op_used[1] && id_rs2 == ex_q.rd));

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        fwd_select u_fwd (
            .ex   (ex_q),
            .mem  (mem_q),
            .src  (op_src[i]),
            .used (op_used[i]),
            .sel  (op_sel[i])
        );
    end

    // STALL always falls back to RUN: the load has moved to MEM by then.
    always_comb begin
        state_nxt  = RUN;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        advance    = 1'b1;
        if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            advance    = 1'b0;
        end else if (state_q == RUN && hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            advance    = 1'b0;
            state_nxt  = STALL;
        end
    end

    assign ex_nxt = advance ? id_ent : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            sh_q      <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            sh_q    <= {sh_q[1], sh_q[0], ex_nxt};
            fwd_a   <= (advance && id_valid) ? op_sel[0] : FWD_RF;
            fwd_b   <= (advance && id_valid) ? op_sel[1] : FWD_RF;
            if (state_q == RUN && state_nxt == STALL && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed per-cycle vectors; each cycle's expected outputs go into a queue and
// a monitor on the falling edge pops and compares them.
module tb_pipe_hazard_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [6:0]  id_opcode = '0;
    logic [4:0]  id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        ex_redirect = 1'b0;
    logic        pc_we, ifid_we, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    typedef struct {
        int          cyc;
        logic        pc_we, ifid_we, ifid_flush, idex_flush;
        logic [1:0]  fwd_a, fwd_b;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
        end
    endtask

    // Monitor: outputs are meaningful every cycle, so one record per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_we",      e.cyc, 16'(pc_we),      16'(e.pc_we));
                chk("ifid_we",    e.cyc, 16'(ifid_we),    16'(e.ifid_we));
                chk("ifid_flush", e.cyc, 16'(ifid_flush), 16'(e.ifid_flush));
                chk("idex_flush", e.cyc, 16'(idex_flush), 16'(e.idex_flush));
                chk("fwd_a",      e.cyc, 16'(fwd_a),      16'(e.fwd_a));
                chk("fwd_b",      e.cyc, 16'(fwd_b),      16'(e.fwd_b));
                chk("stall_cnt",  e.cyc, stall_cnt,       e.cnt);
            end
        end
    end

    // One cycle: apply inputs just after the rising edge, push what must be seen mid-cycle.
    task automatic v(input logic rst, input logic idv, input logic [6:0] opc,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic redir, input logic pw, input logic iw, input logic ifl,
                     input logic idf, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [15:0] cnt);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n = rst; id_valid = idv; id_opcode = opc; id_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; ex_redirect = redir;
        e.cyc = cyc; e.pc_we = pw; e.ifid_we = iw; e.ifid_flush = ifl; e.idex_flush = idf;
        e.fwd_a = fa; e.fwd_b = fb; e.cnt = cnt;
        q.push_back(e);
        cyc++;
    endtask

    task automatic nop(input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
        v(1, 0, 7'd0, 0, 0, 0, 0, 1, 1, 0, 0, fa, fb, cnt);
    endtask

    initial begin
        // reset with live-looking inputs
        v(0, 1, LOAD, 5, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        v(0, 1, OP,   6, 5, 5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        // ADD x5 ; ADD x6,x5,x1 -> EX->MEM forward on rs1
        v(1, 1, OP,   5, 1, 2, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        v(1, 1, OP,   6, 5, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        nop(2'b10, 2'b00, 0);
        nop(2'b00, 2'b00, 0);
        nop(2'b00, 2'b00, 0);
        // LW x5 ; ADD x6,x5,x5 -> one bubble, then WB forward on both
        v(1, 1, LOAD, 5, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        v(1, 1, OP,   6, 5, 5, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
        v(1, 1, OP,   6, 5, 5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        nop(2'b01, 2'b01, 1);
        nop(2'b00, 2'b00, 1);
        // LW x0 ; ADD x6,x0,x0 -> nothing
        v(1, 1, LOAD, 0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        v(1, 1, OP,   6, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        nop(2'b00, 2'b00, 1);
        nop(2'b00, 2'b00, 1);
        // LW x5 ; ADD x6,x5,x0 with redirect in the hazard cycle
        v(1, 1, LOAD, 5, 2, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        v(1, 1, OP,   6, 5, 0, 1, 1, 1, 1, 1, 2'b00, 2'b00, 1);
        nop(2'b00, 2'b00, 1);
        nop(2'b00, 2'b00, 1);
        // ADDI x5 ; ADD x7 ; SW x7 -> 0(x5): rs1 from WB, rs2 from MEM
        v(1, 1, OP_IMM, 5, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        v(1, 1, OP,     7, 1, 2, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        v(1, 1, STORE,  5, 5, 7, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        nop(2'b01, 2'b10, 1);
        nop(2'b00, 2'b00, 1);
        // LW x9 ; ADD x10,x9,x0, reset pulsed during the STALL cycle
        v(1, 1, LOAD, 9, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        v(1, 1, OP,  10, 9, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
        v(0, 1, OP,  10, 9, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        v(1, 1, OP,  10, 9, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        nop(2'b00, 2'b00, 0);
        // redirect during STALL discards the consumer
        v(1, 1, LOAD, 5, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        v(1, 1, OP,   6, 5, 5, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
        v(1, 1, OP,   6, 5, 5, 1, 1, 1, 1, 1, 2'b00, 2'b00, 1);
        nop(2'b00, 2'b00, 1);
        // LW x5 ; LW x6,0(x5) ; ADD x7,x6,x0 -> one stall per dependent pair
        v(1, 1, LOAD, 5, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        v(1, 1, LOAD, 6, 5, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
        v(1, 1, LOAD, 6, 5, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2);
        v(1, 1, OP,   7, 6, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2);
        v(1, 1, OP,   7, 6, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3);
        nop(2'b01, 2'b00, 3);
        nop(2'b00, 2'b00, 3);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
